// File: rtl/framebuffer_writer_pkg.sv
// Shared constants for the framebuffer write path: command bytes, FSM encodings, memory geometry.
// The CHECKSUM state exists only when FB_WRITER_CHECKSUM_EN is defined.
package framebuffer_writer_pkg;

    localparam int unsigned FB_PIXEL_COUNT = 2048;
    localparam int unsigned FB_ADDR_WIDTH  = 11;

    localparam logic [7:0] CMD_FRAME_START = 8'h01;
    localparam logic [7:0] CMD_SET_ADDR    = 8'h02;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ADDR_HI  = 3'd1;
    localparam state_t ST_ADDR_LO  = 3'd2;
    localparam state_t ST_PIX_HI   = 3'd3;
    localparam state_t ST_PIX_LO   = 3'd4;
`ifdef FB_WRITER_CHECKSUM_EN
    localparam state_t ST_CHECKSUM = 3'd5;
`endif

endpackage

// File: rtl/framebuffer_writer_timeout.sv
// Idle-gap timer: counts consecutive cycles with start high and flags the cycle the count
// reaches value. Dropping start clears the count.
module framebuffer_writer_timeout #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    // expired fires on the value-th consecutive counting cycle
    assign expired = start && (count_q == value - WIDTH'(1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (!start || expired) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Decodes the UART byte stream into RGB565 framebuffer writes (full frame or addressed update).
// Optional trailing XOR checksum when FB_WRITER_CHECKSUM_EN is defined.
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = FB_ADDR_WIDTH,
    parameter int unsigned PIXEL_COUNT    = FB_PIXEL_COUNT,
    parameter int unsigned TIMEOUT_CYCLES = 7000,
    parameter int unsigned TIMEOUT_WIDTH  = 13
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_data,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-9:0] addr_hi_q, addr_hi_d;
    logic [7:0]            pix_hi_q, pix_hi_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]           ram_data_q, ram_data_d;
    logic                  ram_we_q, ram_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  timeout;
`ifdef FB_WRITER_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif

    framebuffer_writer_timeout #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_gap_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .start   (busy_q & ~rx_valid),
        .value   (TIMEOUT_WIDTH'(TIMEOUT_CYCLES)),
        .expired (timeout)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_hi_d  = addr_hi_q;
        pix_hi_d   = pix_hi_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
`ifdef FB_WRITER_CHECKSUM_EN
        xor_d      = xor_q;
`endif

        if (rx_valid) begin
`ifdef FB_WRITER_CHECKSUM_EN
            // Command byte and the checksum byte itself stay out of the running XOR
            if (state_q != ST_IDLE && state_q != ST_CHECKSUM) begin
                xor_d = xor_q ^ rx_data;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == CMD_FRAME_START) begin
                        addr_d  = '0;
                        state_d = ST_PIX_HI;
`ifdef FB_WRITER_CHECKSUM_EN
                        xor_d   = '0;
`endif
                    end else if (rx_data == CMD_SET_ADDR) begin
                        state_d = ST_ADDR_HI;
`ifdef FB_WRITER_CHECKSUM_EN
                        xor_d   = '0;
`endif
                    end
                end
                ST_ADDR_HI: begin
                    addr_hi_d = rx_data[ADDR_WIDTH-9:0];
                    state_d   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_d  = {addr_hi_q, rx_data};
                    state_d = ST_PIX_HI;
                end
                ST_PIX_HI: begin
                    pix_hi_d = rx_data;
                    state_d  = ST_PIX_LO;
                end
                ST_PIX_LO: begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_data_d = {pix_hi_q, rx_data};
                    if (addr_q == LAST_ADDR) begin
`ifdef FB_WRITER_CHECKSUM_EN
                        state_d = ST_CHECKSUM;
`else
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_PIX_HI;
                    end
                end
`ifdef FB_WRITER_CHECKSUM_EN
                ST_CHECKSUM: begin
                    done_d  = (rx_data == xor_q);
                    error_d = (rx_data != xor_q);
                    state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            // A half-received pixel is simply dropped; nothing is written
            error_d = 1'b1;
            state_d = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            addr_hi_q  <= '0;
            pix_hi_q   <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addr_hi_q  <= addr_hi_d;
            pix_hi_q   <= pix_hi_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

`ifdef FB_WRITER_CHECKSUM_EN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_we      = ram_we_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_error = error_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer; covers both builds of FB_WRITER_CHECKSUM_EN.
module tb_framebuffer_writer;

`ifdef FB_WRITER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [10:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_we, busy, frame_done, frame_error;

    int n_checks = 0;
    int n_fail = 0;
    int write_count = 0;
    int done_count = 0;
    int error_count = 0;
    int base_w, base_d, base_e;

    logic [7:0]  hi, lo, xr;
    logic [10:0] ad;

    typedef struct {
        logic [7:0]  ah, al, ph, pl;
        logic [10:0] exp_addr;
        logic [15:0] exp_data;
        logic        exp_done;
    } vec_t;
    vec_t vecs[6];

    always #5 clk_in = ~clk_in;

    framebuffer_writer dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    // Pulse counters sample the value held during the cycle that just ended
    always @(posedge clk_in) begin
        if (ram_we)      write_count++;
        if (frame_done)  done_count++;
        if (frame_error) error_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk_in);
    endtask

    // 0x02 07 FE 12 34 AB CD: two writes ending on the last address
    task automatic partial_stream();
        send_byte(8'h02);
        send_byte(8'h07);
        send_byte(8'hFE);
        send_byte(8'h12);
        send_byte(8'h34);
        check("partial w0", {ram_we, frame_done, ram_addr, ram_data}, {2'b10, 11'h7FE, 16'h1234});
        @(negedge clk_in);
        check("partial w0 one-cycle", {30'd0, ram_we, frame_done}, 32'd0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check("partial w1", {ram_we, frame_done, ram_addr, ram_data},
              {1'b1, ~CHK, 11'h7FF, 16'hABCD});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h07, 8'hFF, 8'h12, 8'h34, 11'h7FF, 16'h1234, 1'b1};
        vecs[1] = '{8'hFF, 8'hFF, 8'hAB, 8'hCD, 11'h7FF, 16'hABCD, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h55, 8'hAA, 11'h000, 16'h55AA, 1'b0};
        vecs[3] = '{8'h03, 8'h21, 8'hFF, 8'h00, 11'h321, 16'hFF00, 1'b0};
        vecs[4] = '{8'hF8, 8'h10, 8'h00, 8'h01, 11'h010, 16'h0001, 1'b0};
        vecs[5] = '{8'h04, 8'h00, 8'hDE, 8'hAD, 11'h400, 16'hDEAD, 1'b0};

        // Reset state
        #1 reset = 1'b1;
        #1;
        check("reset outputs", {ram_addr, ram_data, ram_we, busy, frame_done, frame_error}, 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);

        // Junk in IDLE is ignored
        base_w = write_count; base_d = done_count; base_e = error_count;
        send_byte(8'h55);
        check("junk 55 busy", {31'd0, busy}, 32'd0);
        send_byte(8'hFF);
        check("junk FF busy", {31'd0, busy}, 32'd0);
        send_byte(8'h00);
        check("junk 00 busy", {31'd0, busy}, 32'd0);
        @(negedge clk_in);
        check("junk pulses", write_count - base_w + done_count - base_d + error_count - base_e, 0);

        // Full frame
        base_w = write_count; base_d = done_count;
        xr = 8'h00;
        send_byte(8'h01);
        check("frame busy", {31'd0, busy}, 32'd1);
        for (int a = 0; a < 2048; a++) begin
            ad = a[10:0];
            hi = ad[10:3];
            lo = ad[7:0];
            xr = xr ^ hi ^ lo;
            send_byte(hi);
            send_byte(lo);
            check($sformatf("frame write %0d", a), {ram_we, frame_done, ram_addr, ram_data},
                  {1'b1, (a == 2047) && !CHK, ad, hi, lo});
        end
`ifdef FB_WRITER_CHECKSUM_EN
        send_byte(xr);
        check("frame checksum done", {30'd0, frame_done, frame_error}, 32'd2);
`endif
        repeat (3) @(negedge clk_in);
        check("frame write count", write_count - base_w, 2048);
        check("frame done count", done_count - base_d, 1);
        check("frame busy after", {31'd0, busy}, 32'd0);

        // Partial update from 0x7FE
        base_w = write_count;
        partial_stream();
`ifdef FB_WRITER_CHECKSUM_EN
        send_byte(8'hB9);
        check("checksum match", {29'd0, frame_done, frame_error, busy}, 32'b100);
        partial_stream();
        send_byte(8'h46);
        check("checksum mismatch", {29'd0, frame_done, frame_error, busy}, 32'b010);
        @(negedge clk_in);
        check("checksum writes", write_count - base_w, 4);
`else
        @(negedge clk_in);
        check("partial idle", {29'd0, ram_we, frame_done, busy}, 32'd0);
        check("partial writes", write_count - base_w, 2);
`endif

        // Single-pixel addressed writes
        for (int i = 0; i < 6; i++) begin
            pulse_reset();
            send_byte(8'h02);
            send_byte(vecs[i].ah);
            send_byte(vecs[i].al);
            send_byte(vecs[i].ph);
            send_byte(vecs[i].pl);
            check($sformatf("vec %0d", i), {ram_we, frame_done, ram_addr, ram_data},
                  {1'b1, vecs[i].exp_done & ~CHK, vecs[i].exp_addr, vecs[i].exp_data});
        end
        pulse_reset();

        // Timeout after a half pixel
        base_w = write_count; base_e = error_count;
        send_byte(8'h01);
        send_byte(8'hF8);
        repeat (6999) @(negedge clk_in);
        check("timeout not yet", {30'd0, frame_error, busy}, 32'b01);
        @(negedge clk_in);
        check("timeout fires", {29'd0, frame_error, busy, ram_we}, 32'b100);
        @(negedge clk_in);
        check("timeout one-cycle", {31'd0, frame_error}, 32'd0);
        check("timeout no write", write_count - base_w, 0);
        check("timeout error count", error_count - base_e, 1);

        // Byte arriving on the timeout cycle wins
        base_e = error_count;
        send_byte(8'h01);
        send_byte(8'hF8);
        repeat (6998) @(negedge clk_in);
        send_byte(8'h01);
        check("timeout byte wins", {ram_we, frame_error, ram_addr, ram_data},
              {2'b10, 11'h000, 16'hF801});
        repeat (2) @(negedge clk_in);
        check("timeout byte wins no error", error_count - base_e, 0);
        pulse_reset();

        // Asynchronous reset mid-frame
        send_byte(8'h01);
        for (int a = 0; a < 100; a++) begin
            send_byte(8'hA5);
            send_byte(a[7:0]);
        end
        check("midframe before reset", {ram_we, busy, ram_addr, ram_data},
              {2'b11, 11'd99, 16'hA563});
        #2 reset = 1'b1;
        #1;
        check("midframe async reset",
              {ram_addr, ram_data, ram_we, busy, frame_done, frame_error}, 32'd0);
        reset = 1'b0;
        @(negedge clk_in);
        send_byte(8'h01);
        send_byte(8'hC3);
        send_byte(8'h3C);
        check("restart at zero", {ram_we, frame_done, ram_addr, ram_data},
              {2'b10, 11'h000, 16'hC33C});
        pulse_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
